// File: rtl/audio_sample_writer.sv
// Producer side of the circular sample buffer: synchronises the source strobe, writes each sample
// once, and announces every 2W-sample analysis window to the consumer with a valid/ack handshake.
module audio_sample_writer #(
  parameter int unsigned BUFFER_SIZE_BITS = 10,
  parameter int unsigned DATA_WIDTH_BITS  = 16,
  parameter int unsigned WINDOW_SIZE_BITS = 8,
  parameter int unsigned HOP_SIZE_BITS    = 6
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_WIDTH_BITS-1:0]  audio,
  input  logic                        data_ready,
  output logic [BUFFER_SIZE_BITS-1:0] address,
  output logic [DATA_WIDTH_BITS-1:0]  data_in,
  output logic                        write,
  output logic                        window_valid,
  output logic [BUFFER_SIZE_BITS-1:0] window_start,
  input  logic                        window_ack,
  output logic                        overrun,
  output logic                        primed
);

  localparam int unsigned FillW = WINDOW_SIZE_BITS + 2;
  localparam int unsigned HopW  = (HOP_SIZE_BITS > 0) ? HOP_SIZE_BITS : 1;

  localparam logic [FillW-1:0]            FillTarget = FillW'(1) << (WINDOW_SIZE_BITS + 1);
  localparam logic [HopW:0]               HopLen     = (HopW + 1)'(1) << HOP_SIZE_BITS;
  localparam logic [BUFFER_SIZE_BITS-1:0] Span       =
      BUFFER_SIZE_BITS'(1) << (WINDOW_SIZE_BITS + 1);

  typedef enum logic {StFill, StRun} state_e;

  state_e                      state_q, state_d;
  logic                        s1_q, s2_q, s3_q;
  logic [BUFFER_SIZE_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [FillW-1:0]            fill_cnt_q, fill_cnt_d;
  logic [HopW-1:0]             hop_cnt_q, hop_cnt_d;
  logic [BUFFER_SIZE_BITS-1:0] address_q, address_d;
  logic [DATA_WIDTH_BITS-1:0]  data_in_q, data_in_d;
  logic                        write_q, write_d;
  logic                        valid_q, valid_d;
  logic [BUFFER_SIZE_BITS-1:0] start_q, start_d;
  logic                        overrun_q, overrun_d;

  logic                        accept;
  logic                        issue;
  logic [FillW-1:0]            fill_next;
  logic [HopW:0]               hop_next;
  logic [BUFFER_SIZE_BITS-1:0] new_start;

  // Rising edge of the synchronised strobe: one accept per data_ready pulse.
  assign accept    = s2_q & ~s3_q;
  // Oldest sample of the window ending with the sample being written this cycle.
  assign new_start = wr_ptr_q + BUFFER_SIZE_BITS'(1) - Span;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StFill;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      wr_ptr_q   <= '0;
      fill_cnt_q <= '0;
      hop_cnt_q  <= '0;
      address_q  <= '0;
      data_in_q  <= '0;
      write_q    <= 1'b0;
      valid_q    <= 1'b0;
      start_q    <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_q       <= data_ready;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      wr_ptr_q   <= wr_ptr_d;
      fill_cnt_q <= fill_cnt_d;
      hop_cnt_q  <= hop_cnt_d;
      address_q  <= address_d;
      data_in_q  <= data_in_d;
      write_q    <= write_d;
      valid_q    <= valid_d;
      start_q    <= start_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    fill_cnt_d = fill_cnt_q;
    hop_cnt_d  = hop_cnt_q;
    address_d  = address_q;
    data_in_d  = data_in_q;
    write_d    = 1'b0;
    valid_d    = valid_q;
    start_d    = start_q;
    overrun_d  = overrun_q;
    issue      = 1'b0;
    fill_next  = fill_cnt_q + FillW'(1);
    hop_next   = {1'b0, hop_cnt_q} + (HopW + 1)'(1);

    if (accept) begin
      data_in_d = audio;
      address_d = wr_ptr_q;
      write_d   = 1'b1;
      wr_ptr_d  = wr_ptr_q + BUFFER_SIZE_BITS'(1);
      unique case (state_q)
        StFill: begin
          fill_cnt_d = fill_next;
          if (fill_next == FillTarget) begin
            state_d   = StRun;
            hop_cnt_d = '0;
            issue     = 1'b1;
          end
        end
        StRun: begin
          if (hop_next == HopLen) begin
            hop_cnt_d = '0;
            issue     = 1'b1;
          end else begin
            hop_cnt_d = hop_next[HopW-1:0];
          end
        end
      endcase
    end

    // A pending unacked window wins; a colliding new one is dropped and flagged.
    if (issue) begin
      if (!valid_q || window_ack) begin
        valid_d = 1'b1;
        start_d = new_start;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (window_ack) begin
      valid_d = 1'b0;
    end
  end

  assign address      = address_q;
  assign data_in      = data_in_q;
  assign write        = write_q;
  assign window_valid = valid_q;
  assign window_start = start_q;
  assign overrun      = overrun_q;
  assign primed       = (state_q == StRun);

endmodule
